muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit.
- Consumes the two register-file read operands (out_0 -> rs1_value, out_1 -> rs2_value).
- Produces a write-back value plus a one-cycle write-enable pulse, which are muxed onto the register-file DATA / write_enable / Destination_select inputs.
- Drives busy so the core control stalls PC update while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_step.sv | 22 ++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// FSM state encoding, funct3 operation codes and the signed-min helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Most negative two's-complement value for a w-bit word (w <= 64).
  function automatic logic [63:0] signed_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The shifted remainder is below 2*divisor, so the result always fits WIDTH bits.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional build macro: MULDIV_FAST_MUL_EN -- single-cycle combinational
// multiply (RUN skipped for multiplies); divides are unaffected.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_value,
  input  logic [WIDTH-1:0] rs2_value,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             wb_enable,
  output logic [4:0]       rd_out,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   mc_q, mc_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] pr_q, pr_d;       // {acc/remainder, multiplier/quotient}
  logic               neg_q, neg_d;     // negate product or quotient in FIX
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div, sgn1, sgn2, accept, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem, quot_fix, rem_fix;
  logic               div_qbit;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand decode at the accept point: signedness, magnitudes, special cases.
  always_comb begin
    is_div   = funct3[2];
    sgn1     = rs1_value[WIDTH-1] & (is_div ? ~funct3[0] : (funct3 != F3_MULHU));
    sgn2     = rs2_value[WIDTH-1] & (is_div ? ~funct3[0] : ~funct3[1]);
    mag1     = sgn1 ? -rs1_value : rs1_value;
    mag2     = sgn2 ? -rs2_value : rs2_value;
    div_zero = is_div && (rs2_value == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_value == SMIN) && (rs2_value == ONES);
    accept   = start && ((state_q == IDLE) || (state_q == DONE));
  end

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (pr_q[2*WIDTH-1:WIDTH]),
    .divisor      (mc_q),
    .dividend_bit (pr_q[WIDTH-1]),
    .rem_out      (div_rem),
    .q_bit        (div_qbit)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

  // Per-iteration multiply add and the sign fix-ups applied in FIX.
  always_comb begin
    mul_sum  = {1'b0, pr_q[2*WIDTH-1:WIDTH]} + (pr_q[0] ? {1'b0, mc_q} : '0);
    prod_fix = neg_q ? -pr_q : pr_q;
    quot_fix = neg_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -pr_q[2*WIDTH-1:WIDTH] : pr_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath update for IDLE/RUN/FIX/DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    mc_d      = mc_q;
    pr_d      = pr_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      RUN: begin
        if (op_q[2]) pr_d = {div_rem, pr_q[WIDTH-2:0], div_qbit};
        else         pr_d = {mul_sum, pr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[2]) result_d = op_q[1] ? rem_fix : quot_fix;
        else         result_d = (op_q == F3_MUL) ? prod_fix[WIDTH-1:0]
                                                 : prod_fix[2*WIDTH-1:WIDTH];
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          op_d      = funct3;
          rd_d      = rd_in;
          mc_d      = is_div ? mag2 : mag1;
          pr_d      = {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
          neg_d     = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = funct3[1] ? rs1_value : ONES;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : SMIN;
            state_d  = DONE;
          end else begin
            state_d = RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              pr_d    = fast_prod;
              state_d = FIX;
            end
`endif
          end
        end
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; active-low synchronous reset aborts any op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      mc_q      <= '0;
      pr_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      mc_q      <= mc_d;
      pr_q      <= pr_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_enable = done_q;
  assign rd_out    = rd_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] rs1_value = '0;
  logic [W-1:0] rs2_value = '0;
  logic [4:0]   rd_in = '0;
  logic         busy, done, wb_enable;
  logic [4:0]   rd_out;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [W-1:0] last_result = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .rs1_value (rs1_value),
    .rs2_value (rs2_value),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .wb_enable (wb_enable),
    .rd_out    (rd_out),
    .result    (result)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_op(input logic [2:0] f3, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return W + 2;
  endfunction

  // Caller is at a negedge; drives a request, lets the next posedge accept it,
  // then scrambles the inputs so only captured values can matter.
  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd);
    start = 1'b1; funct3 = f3; rs1_value = a; rs2_value = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1_value = $urandom; rs2_value = $urandom; rd_in = 5'($urandom);
  endtask

  // Waits (bounded) for done after an accept edge and checks the transaction.
  task automatic await_done(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [4:0] rd, input int poke);
    logic [W-1:0] exp;
    int lat_exp, lat, bad;
    exp = ref_op(f3, a, b);
    lat_exp = exp_lat(f3, a, b);
    lat = 0;
    bad = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        start = 1'b0;
        break;
      end
      if (busy !== 1'b1 || wb_enable !== 1'b0 || result !== last_result) bad++;
      start = (lat == poke);
      if (start) begin
        funct3 = 3'($urandom); rs1_value = $urandom; rs2_value = $urandom | 1; rd_in = 5'($urandom);
      end
    end
    check({name, "_latency"}, W'(lat), W'(lat_exp));
    check({name, "_result"}, result, exp);
    check({name, "_rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    check({name, "_wb_enable"}, {31'b0, wb_enable}, 32'd1);
    check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({name, "_busy_profile"}, W'(bad), 32'd0);
    last_result = exp;
    $display("%s f3=%0d rs1=%h rs2=%h rd=%0d -> result=%h latency=%0d", name, f3, a, b, rd,
             result, lat);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] rd, input int poke);
    @(negedge clk);
    issue(f3, a, b, rd);
    await_done(name, f3, a, b, rd, poke);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({name, "_result_held"}, result, last_result);
  endtask

  initial begin
    logic [2:0] f3;
    logic [W-1:0] a, b;
    int bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'b0, rd_out}, 32'd0);
    reset = 1'b1;

    // Directed cases
    run_op("mul_7x-3", 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd1, 0);
    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'h2, 5'd4, 0);
    run_op("div_-7/2", 3'b100, 32'hFFFF_FFF9, 32'h2, 5'd5, 0);
    run_op("rem_-7/2", 3'b110, 32'hFFFF_FFF9, 32'h2, 5'd6, 0);
    run_op("divu_100/7", 3'b101, 32'd100, 32'd7, 5'd7, 0);
    run_op("remu_100/7", 3'b111, 32'd100, 32'd7, 5'd8, 0);
    run_op("divu_5/0", 3'b101, 32'd5, 32'd0, 5'd9, 0);
    run_op("rem_5/0", 3'b110, 32'd5, 32'd0, 5'd10, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // Start while busy is ignored
    run_op("div_poke", 3'b100, 32'd1000, 32'hFFFF_FFF3, 5'd13, 10);

    // Back-to-back: start held in the DONE cycle
    @(negedge clk);
    issue(3'b101, 32'd12345, 32'd11, 5'd14);
    await_done("b2b_first", 3'b101, 32'd12345, 32'd11, 5'd14, 0);
    issue(3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);
    await_done("b2b_second", 3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    issue(3'b000, 32'h1234, 32'h5678, 5'd16);
    repeat (15) @(negedge clk);
    check("midop_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", {27'b0, rd_out}, 32'd0);
    reset = 1'b1;
    last_result = '0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_done", W'(bad), 32'd0);
    run_op("after_abort", 3'b111, 32'hCAFE_F00D, 32'd1000, 5'd17, 0);

    // Randomized ops, biased toward the boundary cases
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: begin a = $urandom | 32'h8000_0000; b = $urandom | 32'h8000_0000; end
        default: ;
      endcase
      run_op("rand", f3, a, b, 5'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
